// File: rtl/rr_arb_client_pkg.sv
// Shared types and helpers for the round-robin requester endpoint.
package rr_arb_pkg;

  // Width of the arbiter Req/Grant vectors this client plugs into.
  localparam int NUM_CLIENTS = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    DONE
  } state_t;

  // A zero length means one beat; anything above max_burst is cut to max_burst.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_burst);
    if (len == 0)        return 1;
    if (len > max_burst) return max_burst;
    return len;
  endfunction

endpackage

// File: rtl/rr_arb_client_if.sv
// Client command, beat feed and arbiter/bus signals of one requester.
interface rr_arb_client_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
);
  localparam int LEN_W = $clog2(MAX_BURST + 1);

  logic                  cmd_valid;
  logic [LEN_W-1:0]      cmd_len;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat_ack;
  logic                  req;
  logic                  grant;
  logic                  bus_valid;
  logic [DATA_WIDTH-1:0] bus_data;
  logic                  done;
  logic                  timeout_err;

  // Endpoint side.
  modport slave (
    input  cmd_valid, cmd_len, beat_data, grant,
    output cmd_ready, beat_ack, req, bus_valid, bus_data, done, timeout_err
  );

  // Client / arbiter / bus side.
  modport master (
    output cmd_valid, cmd_len, beat_data, grant,
    input  cmd_ready, beat_ack, req, bus_valid, bus_data, done, timeout_err
  );
endinterface

// File: rtl/rr_arb_client_wait_timer.sv
// Loadable saturating cycle counter with a terminal-count flag.
module rr_wait_timer #(
  parameter int LIMIT = 15,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;

  // Clear beats load beats count; counting stops at LIMIT so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (clr)                      cnt <= '0;
    else if (load)                     cnt <= load_val;
    else if (en && cnt != W'(LIMIT))   cnt <= cnt + 1'b1;
  end

  // High when one more enabled cycle takes the count to LIMIT.
  assign tc = (cnt >= W'(LIMIT - 1));
endmodule

// File: rtl/rr_arb_client.sv
// Requester endpoint: takes a burst command, requests the arbiter and
// streams beats onto the shared bus in granted cycles only.
module rr_arb_client
  import rr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 15,
  localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input logic             clk,
  input logic             rst_n,
  rr_arb_client_if.slave  bus
);
  state_t           state;
  logic             req_r, done_r, to_r;
  logic [LEN_W-1:0] len_r, beat_cnt;
  logic             beat, wait_clr, wait_en, wait_tc;

  // A beat only moves in XFER; grant seen in any other state is dropped.
  assign beat     = (state == XFER) && bus.grant;
  // The wait window only exists in REQ; leaving REQ rearms it.
  assign wait_clr = (state != REQ);
  assign wait_en  = (state == REQ) && !bus.grant;

  rr_wait_timer #(.LIMIT(TIMEOUT)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wait_clr),
    .en       (wait_en),
    .load     (1'b0),
    .load_val ('0),
    .tc       (wait_tc)
  );

  // Burst FSM with registered req/done/timeout_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_r    <= 1'b0;
      done_r   <= 1'b0;
      to_r     <= 1'b0;
      len_r    <= '0;
      beat_cnt <= '0;
    end else begin
      done_r <= 1'b0;
      to_r   <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          len_r    <= LEN_W'(clamp_len(32'(bus.cmd_len), $unsigned(MAX_BURST)));
          beat_cnt <= '0;
          req_r    <= 1'b1;
          state    <= REQ;
        end
        // Grant takes priority over an expiring wait on the same cycle.
        REQ: if (bus.grant) begin
          state <= XFER;
        end else if (wait_tc) begin
          req_r <= 1'b0;
          to_r  <= 1'b1;
          state <= IDLE;
        end
        // Lost grant just pauses: no timeout once the burst has started.
        XFER: if (bus.grant) begin
          if (beat_cnt != LEN_W'(MAX_BURST)) beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == len_r - LEN_W'(1)) begin
            req_r  <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req         = req_r;
  assign bus.done        = done_r;
  assign bus.timeout_err = to_r;
  assign bus.cmd_ready   = (state == IDLE);
  assign bus.bus_valid   = beat;
  assign bus.beat_ack    = beat;
  assign bus.bus_data    = beat ? bus.beat_data : '0;
endmodule

// File: tb/tb_rr_arb_client.sv
// Scoreboard bench for rr_arb_client: expected beats are queued when a
// command is issued and popped as bus_valid beats appear.
module tb_rr_arb_client;
  import rr_arb_pkg::*;

  localparam int DW      = 8;
  localparam int MAXB    = 4;
  localparam int TMO     = 15;
  localparam int LEN_W   = $clog2(MAXB + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arb_client_if #(.DATA_WIDTH(DW), .MAX_BURST(MAXB)) ifc ();

  rr_arb_client #(.DATA_WIDTH(DW), .MAX_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_q[$];  // client beat source
  logic [DW-1:0] exp_q[$];  // expected bus beats

  logic          o_bv, o_ba, o_req, o_done, o_to, o_rdy, o_g, o_has_exp;
  logic [DW-1:0] o_bd, o_exp;

  // One cycle: drive inputs at negedge, sample 1ns later, advance client,
  // pop the scoreboard entry a beat should match. gmode 1: grant follows req.
  task automatic tick(input int gmode, input logic g, input logic cv,
                      input logic [LEN_W-1:0] len);
    @(negedge clk);
    ifc.grant     = (gmode == 1) ? ifc.req : g;
    ifc.cmd_valid = cv;
    ifc.cmd_len   = len;
    ifc.beat_data = (src_q.size() > 0) ? src_q[0] : '0;
    #1;
    o_bv = ifc.bus_valid; o_ba = ifc.beat_ack; o_bd = ifc.bus_data;
    o_req = ifc.req; o_done = ifc.done; o_to = ifc.timeout_err;
    o_rdy = ifc.cmd_ready; o_g = ifc.grant;
    o_has_exp = 1'b0; o_exp = '0;
    if (o_bv === 1'b1 && exp_q.size() > 0) begin
      o_has_exp = 1'b1;
      o_exp = exp_q.pop_front();
    end
    if (o_ba === 1'b1 && src_q.size() > 0) void'(src_q.pop_front());
  endtask

  task automatic test_reset();
    ifc.grant = 1'b1; ifc.cmd_valid = 1'b0; ifc.cmd_len = '0; ifc.beat_data = 8'h5A;
    rst_n = 1'b0;
    #12;
    checks++; if (ifc.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=1", ifc.cmd_ready); end
    checks++; if (ifc.req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", ifc.req); end
    checks++; if (ifc.done !== 1'b0 || ifc.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_pulses done=%b to=%b exp=0/0", ifc.done, ifc.timeout_err); end
    checks++; if (ifc.bus_valid !== 1'b0 || ifc.beat_ack !== 1'b0 || ifc.bus_data !== 8'h00) begin errors++; $display("FAIL rst_bus bv=%b ack=%b data=%h exp=0/0/00", ifc.bus_valid, ifc.beat_ack, ifc.bus_data); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      tick(0, 1'b1, 1'b0, '0);
      checks++; if (o_bv !== 1'b0 || o_to !== 1'b0 || o_rdy !== 1'b1) begin errors++; $display("FAIL idle_grant_ignored bv=%b to=%b rdy=%b exp=0/0/1", o_bv, o_to, o_rdy); end
    end
  endtask

  task automatic test_uncontested();
    int nb = 0, first = -1, last = -1, done_cyc = -1;
    logic req_at_done = 1'bx;
    src_q = {8'hA1, 8'hA2, 8'hA3}; exp_q = src_q;
    tick(0, 1'b0, 1'b1, 3'd3);
    checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL unc_cmd_ready got=%b exp=1", o_rdy); end
    for (int c = 1; c < 30 && done_cyc < 0; c++) begin
      tick(1, 1'b0, 1'b0, '0);
      if (o_bv === 1'b1) begin
        nb++; if (first < 0) first = c; last = c;
        checks++; if (!o_has_exp || o_bd !== o_exp || o_ba !== 1'b1) begin errors++; $display("FAIL unc_beat%0d data=%h ack=%b exp=%h/1", nb, o_bd, o_ba, o_exp); end
      end else if (o_bd !== 8'h00) begin
        checks++; errors++; $display("FAIL unc_idle_data got=%h exp=00", o_bd);
      end
      if (o_done === 1'b1) begin done_cyc = c; req_at_done = o_req; end
    end
    checks++; if (nb != 3) begin errors++; $display("FAIL unc_beat_count got=%0d exp=3", nb); end
    checks++; if (first != 2 || last != 4) begin errors++; $display("FAIL unc_beat_cycles got=%0d..%0d exp=2..4", first, last); end
    checks++; if (done_cyc != 5) begin errors++; $display("FAIL unc_done_cycle got=%0d exp=5", done_cyc); end
    checks++; if (req_at_done !== 1'b0) begin errors++; $display("FAIL unc_req_at_done got=%b exp=0", req_at_done); end
    tick(0, 1'b0, 1'b0, '0);
    checks++; if (o_done !== 1'b0 || o_rdy !== 1'b1) begin errors++; $display("FAIL unc_done_one_cycle done=%b rdy=%b exp=0/1", o_done, o_rdy); end
  endtask

  task automatic test_intermittent();
    int nb = 0, done_cyc = -1;
    logic req_drop = 1'b0, req_at_done = 1'bx, g;
    src_q = {8'hB1, 8'hB2, 8'hB3, 8'hB4}; exp_q = src_q;
    tick(0, 1'b0, 1'b1, 3'd4);
    for (int c = 1; c < 40 && done_cyc < 0; c++) begin
      g = (((c - 1) % NUM_CLIENTS) == 0);
      tick(0, g, (c <= 5), 3'd1);
      if (c <= 5) begin
        checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL int_busy_ready c=%0d got=%b exp=0", c, o_rdy); end
      end
      if (o_bv === 1'b1) begin
        nb++;
        checks++; if (!o_has_exp || o_bd !== o_exp || o_ba !== 1'b1 || o_g !== 1'b1) begin errors++; $display("FAIL int_beat%0d data=%h ack=%b grant=%b exp=%h/1/1", nb, o_bd, o_ba, o_g, o_exp); end
      end
      if (o_done === 1'b1) begin done_cyc = c; req_at_done = o_req; end
      else if (o_req !== 1'b1) req_drop = 1'b1;
    end
    checks++; if (nb != 4) begin errors++; $display("FAIL int_beat_count got=%0d exp=4", nb); end
    checks++; if (done_cyc != 2 + 4 * NUM_CLIENTS) begin errors++; $display("FAIL int_done_cycle got=%0d exp=%0d", done_cyc, 2 + 4 * NUM_CLIENTS); end
    checks++; if (req_drop !== 1'b0 || req_at_done !== 1'b0) begin errors++; $display("FAIL int_req_shape dropped=%b at_done=%b exp=0/0", req_drop, req_at_done); end
    tick(0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_timeout();
    int req_cnt = 0, bv_cnt = 0, to_cnt = 0, to_cyc = -1;
    logic rdy_at_to = 1'bx, req_at_to = 1'bx;
    src_q = {8'hC1, 8'hC2}; exp_q.delete();
    tick(0, 1'b0, 1'b1, 3'd2);
    for (int c = 1; c <= 25; c++) begin
      tick(0, 1'b0, 1'b0, '0);
      if (o_req === 1'b1) req_cnt++;
      if (o_bv !== 1'b0) bv_cnt++;
      if (o_to === 1'b1) begin to_cnt++; to_cyc = c; rdy_at_to = o_rdy; req_at_to = o_req; end
    end
    checks++; if (req_cnt != TMO) begin errors++; $display("FAIL tmo_req_cycles got=%0d exp=%0d", req_cnt, TMO); end
    checks++; if (to_cnt != 1 || to_cyc != TMO + 1) begin errors++; $display("FAIL tmo_pulse count=%0d cycle=%0d exp=1/%0d", to_cnt, to_cyc, TMO + 1); end
    checks++; if (bv_cnt != 0) begin errors++; $display("FAIL tmo_no_beats got=%0d exp=0", bv_cnt); end
    checks++; if (rdy_at_to !== 1'b1 || req_at_to !== 1'b0) begin errors++; $display("FAIL tmo_release rdy=%b req=%b exp=1/0", rdy_at_to, req_at_to); end
    src_q.delete();
  endtask

  task automatic test_boundary_len();
    int nb = 0, done_cyc = -1;
    // length 0 -> one beat
    src_q = {8'hC0, 8'hCF}; exp_q = {8'hC0};
    tick(0, 1'b0, 1'b1, 3'd0);
    for (int c = 1; c < 20 && done_cyc < 0; c++) begin
      tick(1, 1'b0, 1'b0, '0);
      if (o_bv === 1'b1) begin
        nb++;
        checks++; if (!o_has_exp || o_bd !== o_exp) begin errors++; $display("FAIL len0_beat%0d data=%h exp=%h", nb, o_bd, o_exp); end
      end
      if (o_done === 1'b1) done_cyc = c;
    end
    checks++; if (nb != 1 || done_cyc != 3) begin errors++; $display("FAIL len0_count beats=%0d done=%0d exp=1/3", nb, done_cyc); end
    tick(0, 1'b0, 1'b0, '0);
    // length 7 -> clamped to MAX_BURST
    nb = 0; done_cyc = -1;
    src_q = {8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6};
    exp_q = {8'hD0, 8'hD1, 8'hD2, 8'hD3};
    tick(0, 1'b0, 1'b1, 3'd7);
    for (int c = 1; c < 20 && done_cyc < 0; c++) begin
      tick(1, 1'b0, 1'b0, '0);
      if (o_bv === 1'b1) begin
        nb++;
        checks++; if (!o_has_exp || o_bd !== o_exp) begin errors++; $display("FAIL len7_beat%0d data=%h exp=%h", nb, o_bd, o_exp); end
      end
      if (o_done === 1'b1) done_cyc = c;
    end
    checks++; if (nb != MAXB || done_cyc != MAXB + 2) begin errors++; $display("FAIL len7_clamp beats=%0d done=%0d exp=%0d/%0d", nb, done_cyc, MAXB, MAXB + 2); end
    tick(0, 1'b0, 1'b0, '0);
    src_q.delete();
  endtask

  task automatic test_grant_threshold();
    int nb = 0, to_cnt = 0, beat_cyc = -1, done_cyc = -1;
    logic bv_at_thr = 1'bx, bv_at_done = 1'bx;
    src_q = {8'hE5}; exp_q = {8'hE5};
    tick(0, 1'b0, 1'b1, 3'd1);
    for (int c = 1; c <= 22; c++) begin
      tick(0, (c >= TMO), 1'b0, '0);
      if (o_to === 1'b1) to_cnt++;
      if (c == TMO) bv_at_thr = o_bv;
      if (o_bv === 1'b1) begin
        nb++; beat_cyc = c;
        checks++; if (!o_has_exp || o_bd !== o_exp) begin errors++; $display("FAIL thr_beat data=%h exp=%h", o_bd, o_exp); end
      end
      if (o_done === 1'b1) begin done_cyc = c; bv_at_done = o_bv; end
    end
    checks++; if (to_cnt != 0) begin errors++; $display("FAIL thr_no_timeout got=%0d exp=0", to_cnt); end
    checks++; if (bv_at_thr !== 1'b0 || nb != 1 || beat_cyc != TMO + 1) begin errors++; $display("FAIL thr_beat_timing thr_bv=%b beats=%0d cycle=%0d exp=0/1/%0d", bv_at_thr, nb, beat_cyc, TMO + 1); end
    checks++; if (done_cyc != TMO + 2 || bv_at_done !== 1'b0) begin errors++; $display("FAIL thr_done_grant done=%0d bv=%b exp=%0d/0", done_cyc, bv_at_done, TMO + 2); end
  endtask

  task automatic test_reset_mid_burst();
    int nb = 0, done_cyc = -1;
    logic saw_done = 1'b0;
    src_q = {8'hF1, 8'hF2, 8'hF3, 8'hF4}; exp_q = {8'hF1, 8'hF2};
    tick(0, 1'b0, 1'b1, 3'd4);
    for (int c = 1; c < 20 && nb < 2; c++) begin
      tick(1, 1'b0, 1'b0, '0);
      if (o_bv === 1'b1) begin
        nb++;
        checks++; if (!o_has_exp || o_bd !== o_exp) begin errors++; $display("FAIL rmb_beat%0d data=%h exp=%h", nb, o_bd, o_exp); end
      end
    end
    checks++; if (nb != 2) begin errors++; $display("FAIL rmb_pre_beats got=%0d exp=2", nb); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.req !== 1'b0 || ifc.bus_valid !== 1'b0 || ifc.done !== 1'b0) begin errors++; $display("FAIL rmb_async req=%b bv=%b done=%b exp=0/0/0", ifc.req, ifc.bus_valid, ifc.done); end
    checks++; if (ifc.cmd_ready !== 1'b1) begin errors++; $display("FAIL rmb_ready got=%b exp=1", ifc.cmd_ready); end
    repeat (2) begin @(negedge clk); if (ifc.done === 1'b1) saw_done = 1'b1; end
    rst_n = 1'b1;
    src_q.delete(); exp_q.delete();
    src_q = {8'h11}; exp_q = {8'h11};
    nb = 0;
    tick(0, 1'b0, 1'b1, 3'd1);
    if (o_done === 1'b1) saw_done = 1'b1;
    for (int c = 1; c < 20 && done_cyc < 0; c++) begin
      tick(1, 1'b0, 1'b0, '0);
      if (o_bv === 1'b1) begin
        nb++;
        checks++; if (!o_has_exp || o_bd !== o_exp) begin errors++; $display("FAIL rmb_post_beat data=%h exp=%h", o_bd, o_exp); end
      end
      if (o_done === 1'b1) done_cyc = c;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rmb_lost_done got=%b exp=0", saw_done); end
    checks++; if (nb != 1 || done_cyc != 3) begin errors++; $display("FAIL rmb_post_burst beats=%0d done=%0d exp=1/3", nb, done_cyc); end
  endtask

  initial begin
    test_reset();
    test_uncontested();
    test_intermittent();
    test_timeout();
    test_boundary_len();
    test_grant_threshold();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_arb_client.md
Name: rr_arb_client

Overview:
- Requester-side endpoint of the round-robin req/grant protocol. One instance per client.
- Accepts a burst command from the local client and raises `req` toward the arbiter. It then drives beats onto the shared bus only in cycles where its `grant` bit is high.
- Releases `req` after the last beat. Aborts with an error if no grant arrives within a timeout.
- Mid-burst grant loss is normal: the arbiter priority rotates every cycle. The block pauses and resumes.

Parameters:
- DATA_WIDTH, 8, width of beat data.
- MAX_BURST, 4, maximum beats per command. LEN_W = $clog2(MAX_BURST+1).
- TIMEOUT, 15, maximum consecutive REQ-state cycles without grant before abort. Must be ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  client burst command present
- cmd_len  in  LEN_W  beats requested. 0 is treated as 1; values >MAX_BURST are clamped to MAX_BURST.
- cmd_ready  out  1  block idle, command accepted when cmd_valid & cmd_ready
- beat_data  in  DATA_WIDTH  current beat from client; client advances on beat_ack
- beat_ack  out  1  beat consumed this cycle
- req  out  1  request to arbiter (one bit of the arbiter Req vector)
- grant  in  1  this client's bit of the arbiter one-hot Grant vector
- bus_valid  out  1  bus carries this client's beat
- bus_data  out  DATA_WIDTH  beat data on bus
- done  out  1  one-cycle pulse, burst completed
- timeout_err  out  1  one-cycle pulse, request abandoned

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state=IDLE, req=0, done=0, timeout_err=0, beat counter=0, wait counter=0. Combinational outputs are bus_valid=0, beat_ack=0, cmd_ready=1.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the clamped length into len_r and go to REQ. req is registered and goes high the cycle after acceptance.
  - grant seen in IDLE is ignored: no beat, no error.
- REQ:
  - req=1. Wait counter increments each cycle grant=0.
  - grant=1 → XFER the same edge. The first beat goes out in the first XFER cycle with grant=1.
  - Wait counter reaching TIMEOUT with grant=0 → timeout_err pulse on the next cycle, req=0, go to IDLE. No beats are sent.
- XFER:
  - req=1.
  - bus_valid = beat_ack = grant (combinational); bus_data = beat_data when bus_valid, else 0.
  - Beat counter increments on each beat.
  - grant=0 mid-burst: no beat, hold state and counter, req stays high. There is no timeout in XFER.
  - Beat with counter == len_r-1 → DONE.
- DONE:
  - req=0, done=1 for exactly one cycle, then IDLE with cmd_ready=1. Minimum gap between bursts is 1 cycle.
  - A grant arriving in DONE (arbiter latency) must not produce bus_valid.
- Latency, uncontested: cmd accepted at cycle 0 → req high at 1 → first beat at the first cycle with grant, ≥2 → done one cycle after the last beat.
- Counters saturate: the wait counter is width $clog2(TIMEOUT+1); the beat counter is LEN_W bits. Neither wraps.
- Simultaneous grant and timeout threshold in REQ: grant wins, go to XFER, no error.
- Async reset mid-burst: all of the above return to reset values immediately; the partial burst is lost and no done is issued.
- cmd_valid while not IDLE: ignored (cmd_ready=0).

Decomposition:
- Package rr_arb_pkg:
  - state enum (IDLE, REQ, XFER, DONE);
  - function clamp_len;
  - shared localparam NUM_CLIENTS=4, matching the arbiter width.
- One natural sub-module: rr_wait_timer. It is a loadable, saturating cycle counter with clear/enable and a terminal-count flag, reusable for the timeout.
- The FSM and datapath stay in rr_arb_client.

Test Plan:
- Uncontested burst: cmd_len=3, grant tied high once req rises, beat_data 0xA1,0xA2,0xA3 → three consecutive bus_valid beats carrying those values, done pulse 1 cycle after the third, req low in the DONE cycle.
- Intermittent grant: cmd_len=4, grant pattern 1,0,0,0,1,0,0,0,… (4-client rotation) → exactly 4 beats on grant-high cycles only, beat_ack aligned, req high throughout until DONE.
- Timeout: TIMEOUT=15, cmd_len=2, grant held 0 → timeout_err pulses once after 15 REQ cycles, req drops, no bus_valid ever, cmd_ready returns to 1.
- Boundary lengths: cmd_len=0 → exactly 1 beat; cmd_len=7 with MAX_BURST=4 → exactly 4 beats.
- Grant on threshold cycle: grant asserted on the 15th REQ cycle → XFER entered, no timeout_err.
- Reset mid-burst: rst_n low after beat 2 of 4 → req, bus_valid, done drop asynchronously. After release, a new cmd_len=1 completes normally with 1 beat.
